// File: rtl/tcm4_serial_sched_pkg.sv
// tcm4_pkg: shared constants, FSM state and limb-index types for the
// 4-way split serial GF(2)[x] multiplier scheduler.
package tcm4_pkg;
   localparam int WIDTH = 571;
   localparam int NLIMB = 4;
   localparam int LIMB  = (WIDTH + NLIMB - 1) / NLIMB;  // 143
   localparam int PADW  = NLIMB * LIMB;                 // zero-padded operand
   localparam int PW    = 2 * LIMB - 1;                 // limb product width
   localparam int AW    = 8 * LIMB - 1;                 // accumulator width
   localparam int CW    = 2 * WIDTH - 1;                // result width
   localparam int CNTW  = $clog2(LIMB);

   typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
   typedef logic [1:0] limb_idx_t;
endpackage

// File: rtl/tcm4_serial_sched_if.sv
// tcm4_serial_sched_if: start/ready request and done/c response bundle.
interface tcm4_serial_sched_if;
   import tcm4_pkg::*;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [CW-1:0]    c;

   modport master (output start, a, b, input ready, done, c);
   modport slave  (input start, a, b, output ready, done, c);
endinterface

// File: rtl/tcm4_serial_sched_limb.sv
// clmul_serial_limb: bit-serial LIMB x LIMB carry-less multiplier.
// load consumes multiplier bit 0 in the same cycle, then busy runs for
// LIMB-1 more cycles (one bit each, LSB first); last flags the final bit
// cycle and valid pulses in the cycle after it with p stable.
module clmul_serial_limb
   import tcm4_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [LIMB-1:0] x,
   input  logic [LIMB-1:0] y,
   output logic            busy,
   output logic            last,
   output logic            valid,
   output logic [PW-1:0]   p
);
   logic [PW-1:0]   xs;
   logic [LIMB-1:0] ys;
   logic [CNTW-1:0] cnt;

   assign last = busy && (cnt == CNTW'(LIMB - 1));

   // shift-and-xor datapath with bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xs    <= '0;
         ys    <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
         p     <= '0;
      end else begin
         valid <= 1'b0;
         if (load) begin
            p    <= y[0] ? PW'(x) : '0;
            xs   <= PW'(x) << 1;
            ys   <= y >> 1;
            cnt  <= CNTW'(1);
            busy <= 1'b1;
         end else if (busy) begin
            if (ys[0]) p <= p ^ xs;
            xs  <= xs << 1;
            ys  <= ys >> 1;
            cnt <= cnt + CNTW'(1);
            if (last) begin
               busy  <= 1'b0;
               valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/tcm4_serial_sched.sv
// tcm4_serial_sched: schedules the 16 limb-pair products through one
// serial core and xor-accumulates them at offset LIMB*(i+j).
// Optional macro TCM4_SKIP_ZERO_EN: pairs with an all-zero limb are
// skipped in one cycle instead of running the core.
module tcm4_serial_sched
   import tcm4_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   tcm4_serial_sched_if.slave  bus
);
   state_t          state, state_nx;
   logic [PADW-1:0] a_r, b_r;
   limb_idx_t       i_r, j_r;
   logic [AW-1:0]   acc;
   logic [LIMB-1:0] a_l, b_l;
   logic [2:0]      pair_sum;
   logic            last_pair, skip;
   logic            accept, load, adv;
   logic            core_busy, core_last, core_valid;
   logic [PW-1:0]   core_p;
   logic            acc_hi_unused;

   assign a_l       = a_r[LIMB*int'(i_r) +: LIMB];
   assign b_l       = b_r[LIMB*int'(j_r) +: LIMB];
   assign pair_sum  = {1'b0, i_r} + {1'b0, j_r};
   assign last_pair = (i_r == 2'd3) && (j_r == 2'd3);
   assign bus.ready = (state == IDLE);
   // bits above the product width stay zero for in-range operands
   assign acc_hi_unused = ^acc[AW-1:CW];

`ifdef TCM4_SKIP_ZERO_EN
   assign skip = (a_l == '0) || (b_l == '0);
`else
   assign skip = 1'b0;
`endif

   clmul_serial_limb u_core (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .x     (a_l),
      .y     (b_l),
      .busy  (core_busy),
      .last  (core_last),
      .valid (core_valid),
      .p     (core_p)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state and per-cycle controls
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      load     = 1'b0;
      adv      = 1'b0;
      unique case (state)
         IDLE: if (bus.start) begin
            accept   = 1'b1;
            state_nx = MUL;
         end
         MUL: begin
            if (!core_busy) begin
               if (skip) begin
                  adv      = 1'b1;
                  state_nx = last_pair ? DONE : MUL;
               end else begin
                  load = 1'b1;
               end
            end else if (core_last) begin
               state_nx = ACC;
            end
         end
         ACC: begin
            adv      = 1'b1;
            state_nx = last_pair ? DONE : MUL;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // operand latch, pair index, accumulator and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         i_r      <= '0;
         j_r      <= '0;
         acc      <= '0;
         bus.c    <= '0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            a_r        <= PADW'(bus.a);
            b_r        <= PADW'(bus.b);
            acc        <= '0;
            {i_r, j_r} <= 4'd0;
         end
         if (state == ACC && core_valid)
            acc <= acc ^ (AW'(core_p) << (LIMB * int'(pair_sum)));
         if (adv)
            {i_r, j_r} <= {i_r, j_r} + 4'd1;
         if (state == DONE) begin
            bus.done <= 1'b1;
            bus.c    <= acc[CW-1:0];
         end
      end
   end
endmodule

// File: tb/tb_tcm4_serial_sched.sv
// tb_tcm4_serial_sched: scoreboard bench; stimulus pushes expected product
// and latency, a monitor pops and compares on every done pulse.
module tb_tcm4_serial_sched;
   import tcm4_pkg::*;

   typedef struct {
      logic [CW-1:0] c;
      int            lat;
   } exp_t;

   logic clk, rst;
   tcm4_serial_sched_if bus();

   tcm4_serial_sched dut (.clk(clk), .rst(rst), .bus(bus));

   int   total = 0, bad = 0;
   int   cyc = 0;
   int   done_cnt = 0, accept_cnt = 0, killed = 0, rdy_bad = 0;
   exp_t exp_q[$];
   int   acc_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // carry-less product straight from the definition: xor of shifted a
   function automatic logic [CW-1:0] clmul_ref(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [CW-1:0] r;
      r = '0;
      for (int k = 0; k < WIDTH; k++)
         if (y[k]) r = r ^ (CW'(x) << k);
      return r;
   endfunction

   // cycles from accepting edge to the edge that raises done
   function automatic int lat_ref(input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y);
      int n;
      logic [PADW-1:0] px, py;
      px = PADW'(x);
      py = PADW'(y);
      n  = 1;
      for (int i = 0; i < NLIMB; i++)
         for (int j = 0; j < NLIMB; j++) begin
`ifdef TCM4_SKIP_ZERO_EN
            if (px[i*LIMB +: LIMB] == '0 || py[j*LIMB +: LIMB] == '0) n += 1;
            else n += LIMB + 1;
`else
            n += LIMB + 1;
`endif
         end
      return n;
   endfunction

   function automatic logic [CW-1:0] bit_at(input int k);
      logic [CW-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_op();
      logic [575:0] t;
      logic [WIDTH-1:0] r;
      for (int k = 0; k < 18; k++) t[k*32 +: 32] = $urandom();
      r = WIDTH'(t);
      if ($urandom_range(0, 2) == 0) begin
         int z;
         z = $urandom_range(0, 3);
         for (int q = 0; q < LIMB; q++)
            if (z*LIMB + q < WIDTH) r[z*LIMB + q] = 1'b0;
      end
      return r;
   endfunction

   task automatic chk_int(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_c(input string nm, input logic [CW-1:0] act,
                        input logic [CW-1:0] req);
      int fb;
      total++;
      if (act !== req) begin
         bad++;
         fb = -1;
         for (int k = CW - 1; k >= 0; k--) if (act[k] !== req[k]) fb = k;
         $display("FAIL %s first_diff_bit=%0d actual[127:0]=%h required[127:0]=%h",
                  nm, fb, act[127:0], req[127:0]);
      end
   endtask

   // monitor: scores each done pulse, tracks accepts and ready while busy
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               exp_t e;
               int   t0;
               e  = exp_q.pop_front();
               t0 = acc_q.pop_front();
               chk_c("product", bus.c, e.c);
               chk_int("latency", cyc - t0, e.lat);
               chk_int("ready_while_busy", rdy_bad, 0);
               rdy_bad = 0;
            end
         end else if (acc_q.size() > 0 && bus.ready) begin
            rdy_bad++;
         end
         if (bus.start && bus.ready) begin
            acc_q.push_back(cyc + 1);
            accept_cnt++;
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [CW-1:0] expc);
      int n;
      exp_t e;
      n = 0;
      while (!bus.ready && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout actual=0 required=1");
      end else begin
         e.c   = expc;
         e.lat = lat_ref(x, y);
         exp_q.push_back(e);
         bus.a     = x;
         bus.b     = y;
         bus.start = 1'b1;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.a     = rnd_op();
         bus.b     = rnd_op();
      end
   endtask

   task automatic wait_all();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 6000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
         acc_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] x, y;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #1 rst = 1'b1;
      #1;
      chk_int("reset_ready", int'(bus.ready), 1);
      chk_int("reset_done", int'(bus.done), 0);
      chk_c("reset_c", bus.c, '0);
      @(posedge clk);
      #1 rst = 1'b0;

      // directed products, issued back to back
      issue(WIDTH'(1), WIDTH'(1), bit_at(0));
      issue(WIDTH'(3), WIDTH'(3), CW'(5));
      x = '0; x[WIDTH-1] = 1'b1;
      issue(x, x, bit_at(2*WIDTH-2));
      x = '1;
      issue(x, WIDTH'(1), CW'(x));
      x = '0; x[LIMB] = 1'b1;
      issue(x, x, bit_at(2*LIMB));
      issue('0, rnd_op(), '0);
      wait_all();

      // start while busy is ignored
      x = rnd_op();
      y = rnd_op();
      issue(x, y, clmul_ref(x, y));
      repeat (9) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (489) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_all();

      // asynchronous reset mid-operation discards the result
      x = rnd_op();
      y = rnd_op();
      issue(x, y, clmul_ref(x, y));
      repeat (999) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_int("midrst_ready", int'(bus.ready), 1);
      chk_int("midrst_done", int'(bus.done), 0);
      chk_c("midrst_c", bus.c, '0);
      killed += acc_q.size();
      exp_q.delete();
      acc_q.delete();
      rdy_bad = 0;
      @(posedge clk);
      #1 rst = 1'b0;

      issue(WIDTH'(3), WIDTH'(3), CW'(5));
      for (int r = 0; r < 12; r++) begin
         x = rnd_op();
         y = rnd_op();
         issue(x, y, clmul_ref(x, y));
      end
      wait_all();

      chk_int("done_vs_accept", done_cnt, accept_cnt - killed);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
